// File: rtl/hamming_link_fifo.sv
// Hamming(12,8) link buffer: encodes accepted bytes into a FIFO with optional
// error injection, then decodes/corrects on read and hands bytes to a UART TX.
module hamming_link_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic [1:0]               mode,
  input  logic [3:0]               err_pos,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_done,
  output logic                     cw_valid,
  output logic [11:0]              cw_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_WIDTH-1:0]     corr_cnt,
  output logic [CNT_WIDTH-1:0]     uncorr_cnt,
  output logic [CNT_WIDTH-1:0]     ovf_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] c;
    c     = '0;
    c[2]  = d[0];
    c[4]  = d[1];
    c[5]  = d[2];
    c[6]  = d[3];
    c[8]  = d[4];
    c[9]  = d[5];
    c[10] = d[6];
    c[11] = d[7];
    c[0]  = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
    c[1]  = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
    c[3]  = d[1] ^ d[2] ^ d[3] ^ d[7];
    c[7]  = d[4] ^ d[5] ^ d[6] ^ d[7];
    return c;
  endfunction

  function automatic logic [7:0] extract(input logic [11:0] c);
    return {c[11], c[10], c[9], c[8], c[6], c[5], c[4], c[2]};
  endfunction

  // Entry layout: {bypass flag, 12-bit codeword}
  logic [12:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           full, empty, push, pop;
  logic [11:0]    flip_mask;
  logic [12:0]    wr_word, rd_word;
  logic [3:0]     syn;
  logic [7:0]     dec_data;
  logic           dec_corr, dec_uncorr;
  state_t         state;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign pop      = (state == S_IDLE) & ~empty;
  assign rd_word  = mem[rd_ptr];

  // Injection mask; position err_pos+1 wraps 12 -> 1
  always_comb begin
    flip_mask = '0;
    if (err_pos >= 4'd1 && err_pos <= 4'd12) begin
      if (mode == 2'b10 || mode == 2'b11)
        flip_mask = 12'(1) << (err_pos - 4'd1);
      if (mode == 2'b11)
        flip_mask = flip_mask | ((err_pos == 4'd12) ? 12'h001 : (12'(1) << err_pos));
    end
  end

  always_comb begin
    wr_word = {1'b0, encode(in_data) ^ flip_mask};
    if (mode == 2'b01)
      wr_word = {1'b1, 4'b0, in_data};
  end

  // Syndrome decode of the head entry
  always_comb begin
    syn        = '0;
    dec_corr   = 1'b0;
    dec_uncorr = 1'b0;
    for (int i = 1; i <= 12; i++)
      if (rd_word[i-1]) syn = syn ^ 4'(i);
    dec_data = extract(rd_word[11:0]);
    if (rd_word[12]) begin
      dec_data = rd_word[7:0];
    end else if (syn >= 4'd1 && syn <= 4'd12) begin
      dec_data = extract(rd_word[11:0] ^ (12'(1) << (syn - 4'd1)));
      dec_corr = 1'b1;
    end else if (syn != 4'd0) begin
      dec_uncorr = 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_word;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ovf_cnt  <= '0;
      cw_valid <= 1'b0;
      cw_data  <= '0;
    end else begin
      cw_valid <= push;
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        cw_data <= wr_word[11:0];
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (in_valid && full && ovf_cnt != '1)
        ovf_cnt <= ovf_cnt + CNT_WIDTH'(1);
    end
  end

  // Read/transmit FSM
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state      <= S_IDLE;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: if (!empty) begin
          tx_data <= dec_data;
          state   <= S_START;
          if (dec_corr && corr_cnt != '1)
            corr_cnt <= corr_cnt + CNT_WIDTH'(1);
          if (dec_uncorr && uncorr_cnt != '1)
            uncorr_cnt <= uncorr_cnt + CNT_WIDTH'(1);
        end
        S_START: begin
          tx_start <= 1'b1;
          state    <= S_WAIT;
        end
        S_WAIT:  if (tx_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
